// File: rtl/beta_mmio_point_port.sv
// Beta IO-region responder: small register file plus a show-ahead point FIFO
// feeding the laser projector. The CPU pushes points by bus write and the
// projector drains them with a valid/ready handshake. There is also a popped-point
// counter, sticky overflow/underrun flags and a low-water interrupt.
module beta_mmio_point_port #(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_IO,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [11:0] pt_x,
    output logic [11:0] pt_y,
    output logic        pt_laser,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LOW_C   = (AW+1)'(LOW_WATER);

    // Point storage: {laser, y, x}. The head is read asynchronously so the
    // projector sees it in the same cycle it becomes valid (show-ahead).
    logic [24:0]   mem [FIFO_DEPTH];

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          run_reg, irq_en_reg;
    logic          overflow_reg, underrun_reg, irq_pending_reg;
    logic [31:0]   point_count_reg;
    logic [31:0]   read_word;

    logic [2:0]    idx;
    logic          bus_wr, bus_rd;
    logic          push_req, push_ok, ctrl_wr, flush, ack_wr;
    logic          empty, full, pop, pop_eff;
    logic          overflow_set, underrun_set, irq_set;
    logic [24:0]   head;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign unused_bits = ^{addr[31:5], addr[1:0], wdata[31:25]};

    assign idx      = addr[4:2];
    assign bus_wr   = sel_IO & wr;
    assign bus_rd   = sel_IO & ~wr;
    assign push_req = bus_wr & (idx == 3'd0);
    assign ctrl_wr  = bus_wr & (idx == 3'd2);
    assign flush    = ctrl_wr & wdata[2];
    assign ack_wr   = bus_wr & (idx == 3'd3);

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_C);
    assign pt_valid = run_reg & ~empty;
    assign pop      = pt_valid & pt_ready;
    // A flush discards the queue at this edge, so a handshake in the same
    // cycle does not count as a consumed point.
    assign pop_eff  = pop & ~flush;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok      = push_req & (~full | pop_eff);
    assign overflow_set = push_req & full & ~pop_eff;
    assign underrun_set = run_reg & empty & pt_ready;
    assign irq_set      = pop_eff & (count_reg == LOW_C);

    assign head     = mem[rd_ptr_reg];
    assign pt_x     = pt_valid ? head[11:0]  : 12'd0;
    assign pt_y     = pt_valid ? head[23:12] : 12'd0;
    assign pt_laser = pt_valid & head[24];
    assign irq      = irq_pending_reg & irq_en_reg;

    assign status_word = {15'd0, irq_pending_reg, 3'd0, underrun_reg, overflow_reg,
                          empty, full, 9'(count_reg)};

    // Next pointer/count values; flush overrides any concurrent pop.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop_eff) rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({push_ok, pop_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
    end

    // Read mux over pre-edge register state.
    always_comb begin
        read_word = '0;
        case (idx)
            3'd1:    read_word = status_word;
            3'd2:    read_word = {30'd0, irq_en_reg, run_reg};
            3'd4:    read_word = point_count_reg;
            default: read_word = '0;
        endcase
    end

    // Point storage write; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wdata[24:0];
    end

    // FIFO bookkeeping, control, sticky flags, counter and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            run_reg         <= 1'b0;
            irq_en_reg      <= 1'b0;
            overflow_reg    <= 1'b0;
            underrun_reg    <= 1'b0;
            irq_pending_reg <= 1'b0;
            point_count_reg <= '0;
            rdata           <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            if (ctrl_wr) begin
                run_reg    <= wdata[0];
                irq_en_reg <= wdata[1];
            end
            // Sticky bits: a new set beats a same-cycle acknowledge.
            overflow_reg    <= overflow_set | (overflow_reg & ~(ack_wr & wdata[1]));
            underrun_reg    <= underrun_set | (underrun_reg & ~(ack_wr & wdata[2]));
            irq_pending_reg <= irq_set | (irq_pending_reg & ~(ack_wr & wdata[0]));
            if (pop_eff) point_count_reg <= point_count_reg + 1'b1;
            if (bus_rd) rdata <= read_word;
        end
    end

endmodule

// File: tb/tb_beta_mmio_point_port.sv
// Self-checking bench for beta_mmio_point_port: a vector table for the basic
// register behaviour, then hand-written sequences for overflow, low-water
// interrupt, underrun, full push+pop, flush and asynchronous reset.
module tb_beta_mmio_point_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel_IO;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [11:0] pt_x;
    logic [11:0] pt_y;
    logic        pt_laser;
    logic        pt_valid;
    logic        pt_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t        exp_q[$];
    logic [24:0] pt_q[$];

    typedef struct {
        bit          w;
        logic [2:0]  idx;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [24:0] exp_pt;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[16];

    beta_mmio_point_port #(.FIFO_DEPTH(16), .LOW_WATER(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel_IO   (sel_IO),
        .addr     (addr),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .pt_x     (pt_x),
        .pt_y     (pt_y),
        .pt_laser (pt_laser),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic chk_head(input string name, input logic [24:0] exp);
        chk(name, {7'd0, pt_laser, pt_y, pt_x}, {7'd0, exp});
    endtask

    // One bus access, driven at a falling edge and completed at the next one.
    task automatic bus_op(input bit w, input logic [2:0] idx, input logic [31:0] d);
        sel_IO = 1'b1;
        wr     = w;
        addr   = {27'd0, idx, 2'b00};
        wdata  = d;
        @(negedge clk);
        sel_IO = 1'b0;
        wr     = 1'b0;
        wdata  = '0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        bus_op(1'b0, idx, '0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(e.name, rdata, e.val);
        end
    endtask

    task automatic push_pt(input logic [24:0] p, input bit accepted);
        bus_op(1'b1, 3'd0, {7'd0, p});
        if (accepted) pt_q.push_back(p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pt_q.delete();
    endtask

    function automatic logic [24:0] pt_of(input int i);
        logic [24:0] p;
        p = {1'(i & 1), 12'(i + 256), 12'(i + 512)};
        return p;
    endfunction

    // Drain n points with pt_ready held high, checking each head against the model.
    task automatic drain(input int n, input string tag, input bit chk_irq);
        pt_ready = 1'b1;
        for (int k = 1; k <= n; k++) begin
            if (pt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: model queue empty", tag);
            end else begin
                chk_head($sformatf("%s_head%0d", tag, k), pt_q[0]);
                void'(pt_q.pop_front());
            end
            @(negedge clk);
            if (chk_irq) chk($sformatf("%s_irq%0d", tag, k), {31'd0, irq}, 32'(k >= 13));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd1, 32'h0,          32'h400, 1'b0, 25'h0,       1'b0};
        vecs[1]  = '{1'b1, 3'd0, 32'h01123456,   32'h0,   1'b0, 25'h0,       1'b0};
        vecs[2]  = '{1'b0, 3'd1, 32'h0,          32'h001, 1'b0, 25'h0,       1'b0};
        vecs[3]  = '{1'b0, 3'd2, 32'h0,          32'h0,   1'b0, 25'h0,       1'b0};
        vecs[4]  = '{1'b1, 3'd2, 32'h2,          32'h0,   1'b0, 25'h0,       1'b0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0,          32'h2,   1'b0, 25'h0,       1'b0};
        vecs[6]  = '{1'b1, 3'd2, 32'h1,          32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[7]  = '{1'b0, 3'd2, 32'h0,          32'h1,   1'b1, 25'h1123456, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 32'hFFFFFFFF,   32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[9]  = '{1'b0, 3'd1, 32'h0,          32'h001, 1'b1, 25'h1123456, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 32'h0,          32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 32'h0,          32'h1,   1'b1, 25'h1123456, 1'b0};
        vecs[12] = '{1'b0, 3'd3, 32'h0,          32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[13] = '{1'b1, 3'd6, 32'hFFFFFFFF,   32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[14] = '{1'b0, 3'd5, 32'h0,          32'h0,   1'b1, 25'h1123456, 1'b0};
        vecs[15] = '{1'b0, 3'd4, 32'h0,          32'h0,   1'b1, 25'h1123456, 1'b0};

        reset    = 1'b1;
        sel_IO   = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        pt_ready = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_valid", {31'd0, pt_valid}, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        chk_head("reset_pt", 25'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven register behaviour.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].w) begin
                bus_op(1'b1, vecs[i].idx, vecs[i].d);
            end else begin
                rd(vecs[i].idx, vecs[i].exp_rd, $sformatf("vec%0d_rdata", i));
            end
            chk($sformatf("vec%0d_valid", i), {31'd0, pt_valid}, {31'd0, vecs[i].exp_valid});
            chk_head($sformatf("vec%0d_pt", i), vecs[i].exp_pt);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Single pop: valid drops after one handshake cycle.
        pt_ready = 1'b1;
        @(negedge clk);
        pt_ready = 1'b0;
        chk("pop1_valid", {31'd0, pt_valid}, 32'h0);
        rd(3'd4, 32'd1, "pop1_point_count");
        rd(3'd1, 32'h400, "pop1_status");

        // Overflow with run=0, then low-water interrupt and underrun on drain.
        do_reset();
        for (int i = 0; i < 16; i++) push_pt(pt_of(i), 1'b1);
        push_pt(25'h0ABCDEF, 1'b0);
        rd(3'd1, 32'h0A10, "ovf_status");
        bus_op(1'b1, 3'd3, 32'h2);
        rd(3'd1, 32'h0210, "ovf_cleared");
        bus_op(1'b1, 3'd2, 32'h3);
        chk("lw_valid", {31'd0, pt_valid}, 32'h1);
        drain(16, "lw", 1'b1);
        @(negedge clk);
        pt_ready = 1'b0;
        rd(3'd1, 32'h11400, "lw_status_underrun");
        chk("lw_irq_before_ack", {31'd0, irq}, 32'h1);
        bus_op(1'b1, 3'd3, 32'h5);
        chk("lw_irq_after_ack", {31'd0, irq}, 32'h0);
        rd(3'd1, 32'h400, "lw_status_acked");
        rd(3'd4, 32'd16, "lw_point_count");

        // Push into a full FIFO while a pop happens in the same cycle.
        do_reset();
        for (int i = 0; i < 16; i++) push_pt(pt_of(i + 32), 1'b1);
        bus_op(1'b1, 3'd2, 32'h1);
        pt_ready = 1'b1;
        bus_op(1'b1, 3'd0, {7'd0, 25'h1555AAA});
        pt_ready = 1'b0;
        void'(pt_q.pop_front());
        pt_q.push_back(25'h1555AAA);
        rd(3'd1, 32'h0210, "fullpp_status");
        drain(16, "fullpp", 1'b0);
        pt_ready = 1'b0;
        chk("fullpp_valid", {31'd0, pt_valid}, 32'h0);
        rd(3'd1, 32'h10400, "fullpp_status_end");
        chk("fullpp_irq_masked", {31'd0, irq}, 32'h0);

        // Flush concurrent with a handshake.
        do_reset();
        for (int i = 0; i < 8; i++) push_pt(pt_of(i + 64), 1'b1);
        bus_op(1'b1, 3'd2, 32'h1);
        pt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_op(1'b1, 3'd2, 32'h5);
        pt_ready = 1'b0;
        pt_q.delete();
        chk("flush_valid", {31'd0, pt_valid}, 32'h0);
        rd(3'd1, 32'h400, "flush_status");
        rd(3'd4, 32'd2, "flush_point_count");
        rd(3'd2, 32'h1, "flush_ctrl");
        push_pt(pt_of(99), 1'b1);
        chk("flush_repush_valid", {31'd0, pt_valid}, 32'h1);
        chk_head("flush_repush_head", pt_q[0]);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", {31'd0, pt_valid}, 32'h0);
        chk("areset_rdata", rdata, 32'h0);
        chk_head("areset_pt", 25'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(3'd1, 32'h400, "areset_status");
        rd(3'd4, 32'd0, "areset_point_count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
